// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/add/sub/slt/nor plus iterative MIPS-style
// MULT/MULTU/DIV/DIVU writing HI/LO, behind a start/busy/finished handshake.
module alu_multicycle #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  input_a,
  input  logic [WIDTH-1:0]  input_b,
  input  logic [CTRL_W-1:0] control,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              zero,
  output logic              cout,
  output logic              err_overflow,
  output logic              err_invalid_control,
  output logic              err_div_zero,
  output logic              busy,
  output logic              finished
);

  localparam logic [CTRL_W-1:0] OP_AND   = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] OP_OR    = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OP_ADD   = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OP_ADDU  = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] OP_SUB   = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] OP_SLT   = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] OP_NOR   = CTRL_W'(12);
  localparam logic [CTRL_W-1:0] OP_MULT  = CTRL_W'(24);
  localparam logic [CTRL_W-1:0] OP_MULTU = CTRL_W'(25);
  localparam logic [CTRL_W-1:0] OP_DIV   = CTRL_W'(26);
  localparam logic [CTRL_W-1:0] OP_DIVU  = CTRL_W'(27);
  localparam logic [WIDTH-1:0]  MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, EXEC, ITER, FIX} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0]  result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
  logic              inv_q, inv_d, dz_q, dz_d, fin_q, fin_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  logic in_is_mult, in_is_div, in_signed, is_div, op_signed, neg_result, div_ge, div_ovf;
  logic [WIDTH-1:0]   in_a_mag, in_b_mag, a_mag, b_mag, quo_fix, rem_fix;
  logic [WIDTH:0]     add_sum, sub_sum, mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign in_is_mult = (control == OP_MULT) || (control == OP_MULTU);
  assign in_is_div  = (control == OP_DIV)  || (control == OP_DIVU);
  assign in_signed  = (control == OP_MULT) || (control == OP_DIV);
  assign in_a_mag   = magnitude(input_a, in_signed);
  assign in_b_mag   = magnitude(input_b, in_signed);

  assign is_div     = (ctrl_q == OP_DIV) || (ctrl_q == OP_DIVU);
  assign op_signed  = (ctrl_q == OP_MULT) || (ctrl_q == OP_DIV);
  assign a_mag      = magnitude(a_q, op_signed);
  assign b_mag      = magnitude(b_q, op_signed);

  assign add_sum    = {1'b0, a_q} + {1'b0, b_q};
  assign sub_sum    = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);

  // Multiplier shifts out of quo_q while the partial product accumulates in rem_q.
  assign mul_sum    = {1'b0, rem_q} + (quo_q[0] ? {1'b0, a_mag} : '0);
  assign div_shift  = {rem_q, quo_q[WIDTH-1]};
  assign div_ge     = div_shift >= {1'b0, b_mag};
  assign div_diff   = div_shift - {1'b0, b_mag};

  assign neg_result = op_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign prod       = {rem_q, quo_q};
  assign prod_fix   = neg_result ? (~prod + (2*WIDTH)'(1)) : prod;
  assign quo_fix    = neg_result ? (~quo_q + WIDTH'(1)) : quo_q;
  assign rem_fix    = (op_signed && a_q[WIDTH-1]) ? (~rem_q + WIDTH'(1)) : rem_q;
  assign div_ovf    = op_signed && is_div && (a_q == MOST_NEG) && (b_q == '1);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    inv_d    = inv_q;
    dz_d     = dz_q;
    fin_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = input_a;
          b_d    = input_b;
          ctrl_d = control;
          if (in_is_mult || (in_is_div && input_b != '0)) begin
            state_d = ITER;
            cnt_d   = CNT_W'(WIDTH);
            rem_d   = '0;
            quo_d   = in_is_div ? in_a_mag : in_b_mag;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        state_d = IDLE;
        fin_d   = 1'b1;
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
        inv_d   = 1'b0;
        dz_d    = 1'b0;
        case (ctrl_q)
          OP_AND:  result_d = a_q & b_q;
          OP_OR:   result_d = a_q | b_q;
          OP_NOR:  result_d = ~(a_q | b_q);
          OP_ADD: begin
            result_d = add_sum[WIDTH-1:0];
            cout_d   = add_sum[WIDTH];
            ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
          end
          OP_ADDU: begin
            result_d = add_sum[WIDTH-1:0];
            cout_d   = add_sum[WIDTH];
          end
          OP_SUB: begin
            result_d = sub_sum[WIDTH-1:0];
            cout_d   = sub_sum[WIDTH];
            ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_sum[WIDTH-1] != a_q[WIDTH-1]);
          end
          OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
          // Only a zero divisor routes a divide through EXEC.
          OP_DIV, OP_DIVU: begin
            result_d = '1;
            lo_d     = '1;
            hi_d     = a_q;
            dz_d     = 1'b1;
          end
          default: begin
            result_d = '0;
            inv_d    = 1'b1;
          end
        endcase
        zero_d = (result_d == '0);
      end
      ITER: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div) begin
          rem_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], div_ge};
        end else begin
          rem_d = mul_sum[WIDTH:1];
          quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
        end
        if (cnt_d == '0) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        fin_d   = 1'b1;
        cout_d  = 1'b0;
        inv_d   = 1'b0;
        dz_d    = 1'b0;
        if (is_div) begin
          hi_d  = rem_fix;
          lo_d  = quo_fix;
          ovf_d = div_ovf;
        end else begin
          hi_d  = prod_fix[2*WIDTH-1:WIDTH];
          lo_d  = prod_fix[WIDTH-1:0];
          ovf_d = 1'b0;
        end
        result_d = lo_d;
        zero_d   = (lo_d == '0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      dz_q     <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      inv_q    <= inv_d;
      dz_q     <= dz_d;
      fin_q    <= fin_d;
    end
  end

  assign result              = result_q;
  assign hi                  = hi_q;
  assign lo                  = lo_q;
  assign zero                = zero_q;
  assign cout                = cout_q;
  assign err_overflow        = ovf_q;
  assign err_invalid_control = inv_q;
  assign err_div_zero        = dz_q;
  assign busy                = (state_q != IDLE);
  assign finished            = fin_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle (WIDTH=32): a table of ops with
// hand-computed results plus sequences for reset abort, busy-ignore and back-to-back.
module tb_alu_multicycle;

  localparam int W = 32;
  localparam logic [4:0] OP_AND = 5'd0, OP_OR = 5'd1, OP_ADD = 5'd2, OP_ADDU = 5'd3;
  localparam logic [4:0] OP_SUB = 5'd6, OP_SLT = 5'd7, OP_NOR = 5'd12;
  localparam logic [4:0] OP_MULT = 5'd24, OP_MULTU = 5'd25, OP_DIV = 5'd26, OP_DIVU = 5'd27;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] input_a = '0, input_b = '0;
  logic [4:0]   control = '0;
  logic [W-1:0] result, hi, lo;
  logic         zero, cout, err_overflow, err_invalid_control, err_div_zero, busy, finished;

  alu_multicycle #(.WIDTH(W), .CTRL_W(5), .CNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .input_a(input_a), .input_b(input_b), .control(control),
    .result(result), .hi(hi), .lo(lo), .zero(zero), .cout(cout),
    .err_overflow(err_overflow), .err_invalid_control(err_invalid_control),
    .err_div_zero(err_div_zero), .busy(busy), .finished(finished)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]   ctrl;
    logic [W-1:0] a, b, res, hi, lo;
    logic         zero, cout, ovf, inv, dz;
    int           lat;
  } vec_t;

  vec_t vecs[23];
  int   nChecks = 0;
  int   nFails = 0;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulses start for one cycle, then counts cycles from the accepting edge to finished.
  task automatic applyStimulus(input logic [4:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                               output int lat);
    @(negedge clock);
    control = ctrl; input_a = a; input_b = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    checkOutput("busy after accept", 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock); #1;
      if (finished) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic runVector(input int idx);
    int    lat;
    string tag;
    vec_t  v;
    v   = vecs[idx];
    tag = $sformatf("vec%0d", idx);
    applyStimulus(v.ctrl, v.a, v.b, lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.lat));
    checkOutput({tag, " result"}, result, v.res);
    checkOutput({tag, " hi"}, hi, v.hi);
    checkOutput({tag, " lo"}, lo, v.lo);
    checkOutput({tag, " flags z/c/o/i/d"},
                32'({zero, cout, err_overflow, err_invalid_control, err_div_zero}),
                32'({v.zero, v.cout, v.ovf, v.inv, v.dz}));
    checkOutput({tag, " busy at finish"}, 32'(busy), 32'd0);
    @(posedge clock); #1;
    checkOutput({tag, " finished one cycle"}, 32'(finished), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;

    //               ctrl      a             b             res           hi            lo            z  c  o  i  d  lat
    vecs[0]  = '{OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h00000000, 32'h0000003F, 0, 0, 1, 0, 0, 1};
    vecs[1]  = '{OP_ADDU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 32'h0000003F, 1, 1, 0, 0, 0, 1};
    vecs[2]  = '{OP_SUB,   32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h00000000, 32'h0000003F, 0, 0, 0, 0, 0, 1};
    vecs[3]  = '{OP_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h00000000, 32'h0000003F, 0, 1, 1, 0, 0, 1};
    vecs[4]  = '{OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h00000000, 32'h0000003F, 0, 0, 0, 0, 0, 1};
    vecs[5]  = '{OP_OR,    32'h0F000000, 32'h000000F0, 32'h0F0000F0, 32'h00000000, 32'h0000003F, 0, 0, 0, 0, 0, 1};
    vecs[6]  = '{OP_NOR,   32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h0000003F, 0, 0, 0, 0, 0, 1};
    vecs[7]  = '{OP_SLT,   32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0000003F, 0, 0, 0, 0, 0, 1};
    vecs[8]  = '{OP_SLT,   32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h0000003F, 1, 0, 0, 0, 0, 1};
    vecs[9]  = '{OP_SLT,   32'h80000000, 32'h00000001, 32'h00000001, 32'h00000000, 32'h0000003F, 0, 0, 0, 0, 0, 1};
    vecs[10] = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 0, 0, 33};
    vecs[11] = '{5'h0F,    32'h00001234, 32'h00005678, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0, 0, 1, 0, 1};
    vecs[12] = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 0, 0, 0, 0, 0, 33};
    vecs[13] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 0, 0, 0, 0, 33};
    vecs[14] = '{OP_MULT,  32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 32'h00000000, 1, 0, 0, 0, 0, 33};
    vecs[15] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 0, 0, 0, 33};
    vecs[16] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFD, 0, 0, 0, 0, 0, 33};
    vecs[17] = '{OP_DIVU,  32'd100,      32'd7,        32'd14,       32'd2,        32'd14,       0, 0, 0, 0, 0, 33};
    vecs[18] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000, 0, 0, 1, 0, 0, 33};
    vecs[19] = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 1};
    vecs[20] = '{OP_ADD,   32'h00000001, 32'h00000002, 32'h00000003, 32'h00000005, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1};
    vecs[21] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 33};
    vecs[22] = '{OP_DIV,   32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 1};

    // Reset state
    #12;
    checkOutput("reset result", result, '0);
    checkOutput("reset hi", hi, '0);
    checkOutput("reset lo", lo, '0);
    checkOutput("reset flags", 32'({zero, cout, err_overflow, err_invalid_control, err_div_zero, busy, finished}), '0);
    @(negedge clock);
    reset_n = 1'b1;

    // Reset aborts an in-flight MULT without a finished pulse
    @(negedge clock);
    control = OP_MULT; input_a = 32'd7; input_b = 32'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("abort busy/finished", 32'({busy, finished}), '0);
    checkOutput("abort result", result, '0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (finished || busy) seen = 1;
    end
    checkOutput("no activity after abort", 32'(seen), '0);
    applyStimulus(OP_MULT, 32'd7, 32'd9, lat);
    checkOutput("mult7x9 latency", 32'(lat), 32'd33);
    checkOutput("mult7x9 lo", lo, 32'd63);
    checkOutput("mult7x9 hi", hi, 32'd0);

    for (int i = 0; i < 23; i++) runVector(i);

    // start while busy is ignored and operand changes do not disturb the MULT
    @(negedge clock);
    control = OP_MULT; input_a = 32'd3; input_b = 32'd4; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock); #1;
      if (k == 5) begin
        control = OP_ADD; input_a = 32'd100; input_b = 32'd200; start = 1'b1;
      end
      if (k == 6) start = 1'b0;
      if (finished) begin
        lat = k;
        break;
      end
    end
    checkOutput("ignore latency", 32'(lat), 32'd33);
    checkOutput("ignore lo", lo, 32'd12);
    checkOutput("ignore hi", hi, 32'd0);
    @(posedge clock); #1;
    checkOutput("ignore idle after", 32'({busy, finished}), '0);

    // start held high across the finished cycle is accepted immediately
    @(negedge clock);
    control = OP_ADD; input_a = 32'd1; input_b = 32'd1; start = 1'b1;
    @(posedge clock); #1;
    control = OP_SUB; input_a = 32'd9; input_b = 32'd4;
    @(posedge clock); #1;
    checkOutput("b2b first finished", 32'(finished), 32'd1);
    checkOutput("b2b first result", result, 32'd2);
    @(posedge clock); #1;
    start = 1'b0;
    checkOutput("b2b second accepted", 32'({busy, finished}), 32'b10);
    @(posedge clock); #1;
    checkOutput("b2b second finished", 32'(finished), 32'd1);
    checkOutput("b2b second result", result, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
